// File: rtl/hilo_div_unit_if.sv
// Execute-stage HI/LO bus: the pipeline drives operands and control,
// the unit returns the architectural HI/LO values and the divide stall.
interface hilo_div_unit_if;
    logic        op_valid;
    logic        hilo_write;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stall;

    modport master (
        output op_valid, hilo_write, funct, rs_val, rt_val, flush,
        input  hi_o, lo_o, stall
    );

    modport slave (
        input  op_valid, hilo_write, funct, rs_val, rt_val, flush,
        output hi_o, lo_o, stall
    );
endinterface

// File: rtl/hilo_div_unit.sv
// HI/LO register owner: MTHI/MTLO, single-cycle MULT/MULTU and a
// 32-iteration restoring DIV/DIVU that stalls the pipeline while busy.
module hilo_div_unit #(
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            resetn,
    hilo_div_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(DIV_ITERS);

    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        quot_reg, quot_next;
    logic [31:0]        divisor_reg, divisor_next;
    logic [32:0]        rem_reg, rem_next;
    logic               qsign_reg, qsign_next;
    logic               rsign_reg, rsign_next;
    logic [31:0]        hi_reg, hi_next;
    logic [31:0]        lo_reg, lo_next;

    logic        accept;
    logic        is_div;
    logic        is_sdiv;
    logic [31:0] rs_abs;
    logic [31:0] rt_abs;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic [32:0] rem_iter;
    logic [31:0] quot_iter;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        accept  = bus.op_valid & bus.hilo_write & ~bus.flush & (state_reg == IDLE);
        is_div  = (bus.funct == F_DIV) | (bus.funct == F_DIVU);
        is_sdiv = (bus.funct == F_DIV);
        rs_abs  = (is_sdiv & bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
        rt_abs  = (is_sdiv & bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;

        // 64-bit extension makes one truncated multiply serve both signednesses
        mul_a   = (bus.funct == F_MULT) ? {{32{bus.rs_val[31]}}, bus.rs_val} : {32'd0, bus.rs_val};
        mul_b   = (bus.funct == F_MULT) ? {{32{bus.rt_val[31]}}, bus.rt_val} : {32'd0, bus.rt_val};
        product = mul_a * mul_b;

        // Trial result's bit 32 is set exactly when the shifted remainder is below the divisor
        rem_shift = {rem_reg[31:0], quot_reg[31]};
        trial     = rem_shift - {1'b0, divisor_reg};
        rem_iter  = trial[32] ? rem_shift : trial;
        quot_iter = {quot_reg[30:0], ~trial[32]};
        quot_fix  = qsign_reg ? -quot_iter : quot_iter;
        rem_fix   = rsign_reg ? -rem_iter[31:0] : rem_iter[31:0];
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        quot_next    = quot_reg;
        divisor_next = divisor_reg;
        rem_next     = rem_reg;
        qsign_next   = qsign_reg;
        rsign_next   = rsign_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (bus.funct)
                        F_MTHI: hi_next = bus.rs_val;
                        F_MTLO: lo_next = bus.rs_val;
                        F_MULT, F_MULTU: begin
                            hi_next = product[63:32];
                            lo_next = product[31:0];
                        end
                        F_DIV, F_DIVU: begin
                            quot_next    = rs_abs;
                            divisor_next = rt_abs;
                            rem_next     = '0;
                            cnt_next     = '0;
                            qsign_next   = is_sdiv & (bus.rs_val[31] ^ bus.rt_val[31]);
                            rsign_next   = is_sdiv & bus.rs_val[31];
                            state_next   = BUSY;
                        end
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else begin
                    rem_next  = rem_iter;
                    quot_next = quot_iter;
                    cnt_next  = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(DIV_ITERS - 1)) begin
                        hi_next    = rem_fix;
                        lo_next    = quot_fix;
                        state_next = DONE;
                    end
                end
            end
            // Retire cycle: the held divide must not be accepted a second time
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            quot_reg    <= '0;
            divisor_reg <= '0;
            rem_reg     <= '0;
            qsign_reg   <= 1'b0;
            rsign_reg   <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            quot_reg    <= quot_next;
            divisor_reg <= divisor_next;
            rem_reg     <= rem_next;
            qsign_reg   <= qsign_next;
            rsign_reg   <= rsign_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    assign bus.hi_o  = hi_reg;
    assign bus.lo_o  = lo_reg;
    assign bus.stall = (state_reg == BUSY) | (accept & is_div);
endmodule

// File: tb/tb_hilo_div_unit.sv
// Bench for hilo_div_unit: vector table through a scoreboard queue, plus
// hand-driven reset, flush and no-write corner sequences.
module tb_hilo_div_unit;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam int NVEC = 12;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          stall;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t vecs[NVEC];

    hilo_div_unit_if bus();

    hilo_div_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.op_valid   = 1'b0;
        bus.hilo_write = 1'b0;
        bus.funct      = 6'd0;
        bus.rs_val     = 32'd0;
        bus.rt_val     = 32'd0;
        bus.flush      = 1'b0;
    endtask

    // Drives one instruction, holds it while stalled (scrambling operands to
    // prove they were latched), then compares the retired result.
    task automatic run_op(input vec_t v);
        int   cyc;
        exp_t e;
        sb_q.push_back('{hi: v.exp_hi, lo: v.exp_lo, stall: v.exp_stall});
        @(negedge clk);
        bus.op_valid   = 1'b1;
        bus.hilo_write = 1'b1;
        bus.funct      = v.funct;
        bus.rs_val     = v.rs;
        bus.rt_val     = v.rt;
        bus.flush      = 1'b0;
        cyc = 0;
        #1;
        while (bus.stall && cyc < 100) begin
            cyc++;
            @(negedge clk);
            bus.rs_val = $urandom;
            bus.rt_val = $urandom;
            #1;
        end
        if (cyc >= 100) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout got=%0d expected<100", cyc);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        e = sb_q.pop_front();
        check("hi", bus.hi_o, e.hi);
        check("lo", bus.lo_o, e.lo);
        check("stall_cycles", 32'(cyc), 32'(e.stall));
        $display("op funct=%b rs=%h rt=%h -> hi=%h lo=%h stall_cycles=%0d",
                 v.funct, v.rs, v.rt, bus.hi_o, bus.lo_o, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{F_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
        vecs[1]  = '{F_MTLO,  32'hCAFEF00D, 32'h0,        32'h12345678, 32'hCAFEF00D, 0};
        vecs[2]  = '{F_MULT,  32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, 0};
        vecs[3]  = '{F_MULTU, 32'hFFFFFFFD, 32'h5,        32'h00000004, 32'hFFFFFFF1, 0};
        vecs[4]  = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[5]  = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[6]  = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[7]  = '{F_DIVU,  32'h55,       32'h0,        32'h00000055, 32'hFFFFFFFF, 33};
        vecs[8]  = '{F_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'h00000001, 33};
        vecs[9]  = '{F_DIV,   32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 33};
        vecs[10] = '{6'b010000, 32'h11111111, 32'h22222222, 32'h00000002, 32'hFFFFFFF2, 0};
        vecs[11] = '{F_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 33};

        idle_inputs();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("reset_hi", bus.hi_o, 32'h0);
        check("reset_lo", bus.lo_o, 32'h0);
        check("reset_stall", {31'd0, bus.stall}, 32'h0);
        $display("reset hi=%h lo=%h stall=%b", bus.hi_o, bus.lo_o, bus.stall);

        for (int i = 0; i < NVEC; i++) run_op(vecs[i]);

        // op_valid low with hilo_write high: no write
        @(negedge clk);
        bus.hilo_write = 1'b1;
        bus.funct      = F_MTHI;
        bus.rs_val     = 32'hDEADBEEF;
        #1;
        check("bubble_stall", {31'd0, bus.stall}, 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("bubble_hi", bus.hi_o, 32'h0);
        $display("bubble MTHI hi=%h", bus.hi_o);

        // flush in IDLE blocks acceptance
        @(negedge clk);
        bus.op_valid   = 1'b1;
        bus.hilo_write = 1'b1;
        bus.funct      = F_MTLO;
        bus.rs_val     = 32'h00001234;
        bus.flush      = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        check("idle_flush_lo", bus.lo_o, 32'hFFFFFFFF);
        $display("idle flush MTLO lo=%h", bus.lo_o);

        // DIVU flushed at T10: no write, stall gone from T11
        @(negedge clk);
        bus.op_valid   = 1'b1;
        bus.hilo_write = 1'b1;
        bus.funct      = F_DIVU;
        bus.rs_val     = 32'd100;
        bus.rt_val     = 32'd7;
        #1;
        check("div_t0_stall", {31'd0, bus.stall}, 32'h1);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("div_t10_stall", {31'd0, bus.stall}, 32'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("flush_t11_stall", {31'd0, bus.stall}, 32'h0);
        check("flush_hi", bus.hi_o, 32'h0);
        check("flush_lo", bus.lo_o, 32'hFFFFFFFF);
        repeat (30) @(negedge clk);
        #1;
        check("flush_late_lo", bus.lo_o, 32'hFFFFFFFF);
        $display("flushed DIVU hi=%h lo=%h stall=%b", bus.hi_o, bus.lo_o, bus.stall);
        run_op('{F_MTLO, 32'hA5A5A5A5, 32'h0, 32'h0, 32'hA5A5A5A5, 0});

        // reset at T10 of a DIVU
        @(negedge clk);
        bus.op_valid   = 1'b1;
        bus.hilo_write = 1'b1;
        bus.funct      = F_DIVU;
        bus.rs_val     = 32'd1000;
        bus.rt_val     = 32'd3;
        repeat (10) @(negedge clk);
        idle_inputs();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("midrst_stall", {31'd0, bus.stall}, 32'h0);
        check("midrst_hi", bus.hi_o, 32'h0);
        check("midrst_lo", bus.lo_o, 32'h0);
        repeat (30) @(negedge clk);
        #1;
        check("midrst_late_lo", bus.lo_o, 32'h0);
        $display("reset mid-DIVU hi=%h lo=%h stall=%b", bus.hi_o, bus.lo_o, bus.stall);

        // random activity, then a 3-cycle reset
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.op_valid   = 1'b1;
            bus.hilo_write = 1'b1;
            case ($urandom_range(0, 3))
                0:       bus.funct = F_MTHI;
                1:       bus.funct = F_MTLO;
                2:       bus.funct = F_MULT;
                default: bus.funct = F_DIVU;
            endcase
            bus.rs_val = $urandom | 32'h1;
            bus.rt_val = $urandom | 32'h1;
        end
        @(negedge clk);
        idle_inputs();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst3_hi", bus.hi_o, 32'h0);
        check("rst3_lo", bus.lo_o, 32'h0);
        check("rst3_stall", {31'd0, bus.stall}, 32'h0);
        $display("reset after activity hi=%h lo=%h stall=%b", bus.hi_o, bus.lo_o, bus.stall);
        resetn = 1'b1;
        run_op('{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Execute-stage consumer of the decoder's hilo_write control; owns the architectural HI/LO registers.
- Performs MTHI/MTLO and single-cycle MULT/MULTU.
- Performs DIV/DIVU with a 32-iteration restoring divider, stalling the pipeline while busy.
- hi_o/lo_o feed the MFHI/MFLO result path.

Parameters:
- DIV_ITERS, 32, divider iterations; fixed at 32 for 32-bit operands, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  synchronous, active-low reset
- op_valid  input  1  instruction in EX is valid (not a bubble)
- hilo_write  input  1  decoder control: instruction targets HI/LO
- funct  input  6  instr[5:0] of EX instruction
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- flush  input  1  pipeline flush, kills in-flight op
- hi_o  output  32  current HI
- lo_o  output  32  current LO
- stall  output  1  hold IF/ID/EX while divide in progress

Behaviour:
- Reset (resetn=0 at clk edge): hi_o=0, lo_o=0, state=IDLE, counter=0, stall=0. Overrides every other input, including mid-divide.
- Accept condition: op_valid & hilo_write & ~flush & state==IDLE.
  - If false, hi/lo hold.
  - Unknown funct with hilo_write=1: no effect.
- funct 010001 MTHI: hi <= rs_val at the accept edge; lo unchanged.
- funct 010011 MTLO: lo <= rs_val at the accept edge; hi unchanged.
- funct 011000 MULT: {hi,lo} <= signed 64-bit rs_val*rt_val at the accept edge.
- funct 011001 MULTU: same as MULT, unsigned.
- MTHI/MTLO/MULT/MULTU all have 1-cycle latency and never assert stall.
- funct 011010 DIV / 011011 DIVU:
  - Accept cycle T0:
    - stall=1, combinational from inputs.
    - Latch |rs|, |rt| (raw values for DIVU), quotient-sign = rs[31]^rt[31] (DIV only), remainder-sign = rs[31] (DIV only).
    - Clear partial remainder (33 bits); counter=0; state -> BUSY.
  - BUSY, cycles T1..T32: one restoring iteration per cycle.
    - Shift {rem,quot} left 1.
    - Trial-subtract the divisor; keep the result if non-negative and set quot bit.
    - counter increments; stall=1 throughout.
  - End of T32 (counter==31 iteration):
    - Apply sign fixups (negate quotient if quotient-sign, negate remainder if remainder-sign).
    - lo <= quotient, hi <= remainder; state -> DONE.
  - DONE, cycle T33: stall=0 so the divide retires from EX.
    - The same instruction, still presented with op_valid, is NOT re-accepted.
    - State -> IDLE unconditionally.
  - Total stall: 33 cycles (T0..T32). Result is visible on hi_o/lo_o from T33.
- Divide by zero: no exception; same timing.
  - DIVU result: lo=32'hFFFFFFFF, hi=rs_val.
  - DIV result: natural restoring result on magnitudes, then sign fixups applied.
- Overflow case 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0. Magnitude arithmetic is 33-bit, so no special case is needed.
- Flush:
  - In IDLE: blocks acceptance.
  - In BUSY or DONE: state -> IDLE next edge, hi/lo unchanged, stall deasserts next cycle.
  - Flush in the same cycle as a BUSY-final iteration: flush wins, no write.
- stall = (state==BUSY) | (accept & funct is DIV/DIVU). Never asserted in DONE or IDLE otherwise.
- While stalled, upstream holds inputs; operand changes during BUSY are ignored because operands are latched.
- MFHI/MFLO read hi_o/lo_o directly. A write at edge N is visible to an instruction in EX in cycle N+1; no internal bypass.

Test Plan:
- Reset: hold resetn=0 3 cycles after random activity -> hi_o=0, lo_o=0, stall=0. Assert resetn=0 at T10 of a DIVU -> IDLE next edge, hi/lo=0.
- MTHI rs=0x12345678, then MTLO rs=0xCAFEF00D -> hi_o=0x12345678 after first edge, lo_o=0xCAFEF00D after second. op_valid=0 with hilo_write=1 -> no change.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1. stall never 1.
- DIVU rs=100, rt=7 -> stall high exactly 33 cycles, lo=14, hi=2 at T33. The held instruction is not re-executed (exactly one 33-cycle stall).
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU rs=0x55, rt=0 -> lo=0xFFFFFFFF, hi=0x55.
- DIVU with flush at T10 -> stall=0 from T11, hi/lo retain prior values. A following MTLO is accepted normally.
